// File: rtl/ras_sched.sv
// ras_sched: arbitrates fetch (A) and replay FIFO (B) ops onto a RAS, with flush unwind; RAS_SCHED_STAT_EN adds an overflow counter
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
module ras_sched #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic                   a_push,
  input  logic                   a_pop,
  input  logic [`ADDR_WIDTH-1:0] a_addr,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic                   b_push,
  input  logic                   b_pop,
  input  logic [`ADDR_WIDTH-1:0] b_addr,
  output logic                   b_ready,
  input  logic                   flush_valid,
  input  logic [7:0]             flush_cnt,
  output logic                   busy,
  output logic                   ras_push,
  output logic                   ras_pop,
  output logic [`ADDR_WIDTH-1:0] ras_addr,
  input  logic                   ras_full_add,
  output logic [31:0]            stat_full_cnt
);
  localparam int AW = `ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] UNWIND = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [AW+1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    rem_q, rem_d;
  logic          ras_push_q, ras_pop_q;
  logic [AW-1:0] ras_addr_q;
  logic          idle, empty, full, b_force, a_fire, head_issue, unw_issue, issue, enq;
  logic          iss_push, iss_pop;
  logic [AW-1:0] iss_addr;
  logic [AW+1:0] head;
  // arbitration, FIFO bookkeeping and unwind sequencing
  always_comb begin
    idle       = state_q == IDLE;
    empty      = wr_q == rd_q;
    full       = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    b_force    = starve_q == SW'(STARVE_LIMIT);
    a_ready    = idle && !flush_valid && !b_force;
    b_ready    = idle && !flush_valid && !full;
    busy       = !idle;
    a_fire     = a_valid && a_ready;
    head_issue = idle && !flush_valid && !empty && (b_force || !a_fire);
    unw_issue  = !idle && !flush_valid;
    issue      = head_issue || a_fire || unw_issue;
    head       = mem_q[rd_q[PW-1:0]];
    iss_push   = head_issue ? head[AW+1] : a_fire && a_push;
    iss_pop    = head_issue ? head[AW] : (a_fire ? a_pop : unw_issue);
    iss_addr   = head_issue ? head[AW-1:0] : (a_fire ? a_addr : '0);
    enq        = b_valid && b_ready && (b_push || b_pop);
    wr_d       = flush_valid ? '0 : wr_q + (PW+1)'(enq);
    rd_d       = flush_valid ? '0 : rd_q + (PW+1)'(head_issue);
    starve_d   = (flush_valid || empty || head_issue) ? '0 :
                 (idle && !b_force) ? starve_q + SW'(1) : starve_q;
    rem_d      = flush_valid ? flush_cnt : (unw_issue ? rem_q - 8'd1 : rem_q);
    state_d    = flush_valid ? ((flush_cnt != 8'd0) ? UNWIND : IDLE) :
                 (unw_issue && rem_q == 8'd1) ? IDLE : state_q;
  end
  // control state and registered RAS op; address holds when nothing issues
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      starve_q   <= '0;
      rem_q      <= '0;
      ras_push_q <= 1'b0;
      ras_pop_q  <= 1'b0;
      ras_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      starve_q   <= starve_d;
      rem_q      <= rem_d;
      ras_push_q <= issue && iss_push;
      ras_pop_q  <= issue && iss_pop;
      if (issue) ras_addr_q <= iss_addr;
    end
  end
  // B op storage; entries need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_q[PW-1:0]] <= {b_push, b_pop, b_addr};
  end
  assign ras_push = ras_push_q;
  assign ras_pop  = ras_pop_q;
  assign ras_addr = ras_addr_q;
`ifdef RAS_SCHED_STAT_EN
  logic [31:0] stat_q;
  // saturating count of RAS overflow events
  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else if (ras_full_add && stat_q != '1) stat_q <= stat_q + 32'd1;
  end
  assign stat_full_cnt = stat_q;
`else
  logic unused_full_add;
  assign unused_full_add = ras_full_add;
  assign stat_full_cnt   = '0;
`endif
endmodule
